// File: rtl/serializer_4bit_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the frame width default, FSM state encoding and the counter-width helper.
// Imported by the controller and the top level.
package serializer_4bit_pkg;

  // Frame width shared with the downstream 4-bit serial-in shift register.
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Number of bits needed to count 0..value-1 (at least 1 for value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serializer_ctrl.sv
// Serializer control: IDLE/SHIFT FSM plus the bit counter.
// Produces load/shift strobes for the data path and done_next for the DONE register.
// READY is high in IDLE and on the last bit of a word, so words can run back to back.
module serializer_ctrl
  import serializer_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load_req,
  output logic ready,
  output logic busy,
  output logic load_en,
  output logic shift_en,
  output logic done_next
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_LAST);

  // State and counter registers; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a word starts from IDLE or chains on at the last bit; otherwise count bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = load_req ? ST_SHIFT : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: handshake, busy flag, data-path strobes and the pre-registered DONE.
  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    done_next = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ready     = last_bit;
        done_next = last_bit;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
    load_en  = ready && load_req;
    shift_en = busy && !load_en;
  end

endmodule

// File: rtl/serializer_4bit.sv
// Parallel-in serial-out transmitter feeding a serial-in shift register's Din.
// Word accepted at edge k: bits on Dout in cycles k+1..k+WIDTH, DONE high after edge k+WIDTH.
// READY gates LOAD; a LOAD while READY is low is ignored and DATA is not sampled.
module serializer_4bit
  import serializer_4bit_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD,
  output logic             READY,
  output logic             Dout,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             load_en, shift_en, done_next;

  serializer_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk      (CLK),
    .rst      (RST),
    .load_req (LOAD),
    .ready    (READY),
    .busy     (BUSY),
    .load_en  (load_en),
    .shift_en (shift_en),
    .done_next(done_next)
  );

  // Next data: load a new word, or move one place toward the output end filling with IDLE_LEVEL.
  always_comb begin
    shreg_d = shreg_q;
    if (load_en) begin
      shreg_d = DATA;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], IDLE_LEVEL};
      end else begin
        shreg_d = {IDLE_LEVEL, shreg_q[WIDTH-1:1]};
      end
    end
    done_d = done_next;
  end

  // Data shift register and DONE output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  // Dout comes only from flops (state and shift register), never from LOAD or DATA.
  assign Dout = BUSY ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;
  assign DONE = done_q;

endmodule

// File: tb/tb_serializer_4bit.sv
// Bench for serializer_4bit: default, LSB-first and IDLE_LEVEL=1 instances,
// each feeding a model of the downstream 4-bit shift register (B3..B0, shifting toward B3).
module tb_serializer_4bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (MSB first, idle low)
  logic       rst_a, load_a, ready_a, dout_a, busy_a, done_a;
  logic [3:0] data_a;
  // Instance L: LSB first
  logic       rst_l, load_l, ready_l, dout_l, busy_l, done_l;
  logic [3:0] data_l;
  // Instance I: idle level high
  logic       rst_i, load_i, ready_i, dout_i, busy_i, done_i;
  logic [3:0] data_i;

  serializer_4bit u_dut_a (
    .CLK(clk), .RST(rst_a), .DATA(data_a), .LOAD(load_a),
    .READY(ready_a), .Dout(dout_a), .BUSY(busy_a), .DONE(done_a)
  );

  serializer_4bit #(.MSB_FIRST(1'b0)) u_dut_l (
    .CLK(clk), .RST(rst_l), .DATA(data_l), .LOAD(load_l),
    .READY(ready_l), .Dout(dout_l), .BUSY(busy_l), .DONE(done_l)
  );

  serializer_4bit #(.IDLE_LEVEL(1'b1)) u_dut_i (
    .CLK(clk), .RST(rst_i), .DATA(data_i), .LOAD(load_i),
    .READY(ready_i), .Dout(dout_i), .BUSY(busy_i), .DONE(done_i)
  );

  // Downstream serial-in registers
  logic [3:0] b_a = 4'b0000;
  logic [3:0] b_l = 4'b0000;
  always @(posedge clk) begin
    b_a <= {b_a[2:0], dout_a};
    b_l <= {b_l[2:0], dout_l};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] dat;
    logic       dout;
    logic       busy;
    logic       rdy;
    logic       done;
    logic       chk_b;
    logic [3:0] b;
  } vec_t;

  vec_t tbl [23];

  initial begin
    logic [3:0] word;

    //          ld  dat     dout busy rdy  done chkb b
    tbl = '{
      '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}, // accept 1011
      '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000}, // last bit
      '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1011}, // DONE
      '{1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}, // accept 1100
      '{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000}, // chain 0011
      '{1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100}, // DONE #1
      '{1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011}, // DONE #2
      '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}, // accept 1001
      '{1'b0, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}, // ignored LOAD
      '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1001}, // single DONE
      '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}  // no second DONE
    };

    rst_a = 1'b1; load_a = 1'b0; data_a = 4'b0000;
    rst_l = 1'b1; load_l = 1'b0; data_l = 4'b0000;
    rst_i = 1'b1; load_i = 1'b0; data_i = 4'b0000;
    #3;
    chk("rst_dout_a",  {3'b0, dout_a},  4'd0);
    chk("rst_busy_a",  {3'b0, busy_a},  4'd0);
    chk("rst_ready_a", {3'b0, ready_a}, 4'd1);
    chk("rst_done_a",  {3'b0, done_a},  4'd0);
    chk("rst_dout_i",  {3'b0, dout_i},  4'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b0; rst_l = 1'b0; rst_i = 1'b0;
    next_cycle();

    // Idle level high, no LOAD for 10 cycles
    for (int c = 0; c < 10; c++) begin
      chk("idle_dout_i", {3'b0, dout_i}, 4'd1);
      chk("idle_done_i", {3'b0, done_i}, 4'd0);
      next_cycle();
    end

    // Table-driven: single word, back-to-back, ignored load
    for (int v = 0; v < 23; v++) begin
      load_a = tbl[v].ld;
      data_a = tbl[v].dat;
      #1;
      chk($sformatf("v%0d_dout", v),  {3'b0, dout_a},  {3'b0, tbl[v].dout});
      chk($sformatf("v%0d_busy", v),  {3'b0, busy_a},  {3'b0, tbl[v].busy});
      chk($sformatf("v%0d_ready", v), {3'b0, ready_a}, {3'b0, tbl[v].rdy});
      chk($sformatf("v%0d_done", v),  {3'b0, done_a},  {3'b0, tbl[v].done});
      if (tbl[v].chk_b) chk($sformatf("v%0d_b", v), b_a, tbl[v].b);
      next_cycle();
    end
    load_a = 1'b0;

    // Reset mid-word: 1111, assert RST between edges during bit 3
    load_a = 1'b1; data_a = 4'b1111;
    next_cycle();
    load_a = 1'b0;
    next_cycle();
    next_cycle();
    chk("mid_busy_before", {3'b0, busy_a}, 4'd1);
    chk("mid_dout_before", {3'b0, dout_a}, 4'd1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("arst_dout",  {3'b0, dout_a},  4'd0);
    chk("arst_busy",  {3'b0, busy_a},  4'd0);
    chk("arst_ready", {3'b0, ready_a}, 4'd1);
    chk("arst_done",  {3'b0, done_a},  4'd0);
    next_cycle();
    rst_a = 1'b0;
    next_cycle();
    chk("post_rst_done", {3'b0, done_a}, 4'd0);
    chk("post_rst_busy", {3'b0, busy_a}, 4'd0);
    word = 4'b0101;
    load_a = 1'b1; data_a = word;
    next_cycle();
    load_a = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      chk($sformatf("rl_dout_bit%0d", k), {3'b0, dout_a}, {3'b0, word[k]});
      chk("rl_done_low", {3'b0, done_a}, 4'd0);
      next_cycle();
    end
    chk("rl_done", {3'b0, done_a}, 4'd1);
    chk("rl_b", b_a, 4'b0101);
    chk("rl_ready", {3'b0, ready_a}, 4'd1);

    // LSB-first: 0001 sends 1,0,0,0 and leaves B3..B0 = 1000
    word = 4'b0001;
    load_l = 1'b1; data_l = word;
    next_cycle();
    load_l = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lsb_dout_bit%0d", k), {3'b0, dout_l}, {3'b0, word[k]});
      chk("lsb_busy", {3'b0, busy_l}, 4'd1);
      next_cycle();
    end
    chk("lsb_done", {3'b0, done_l}, 4'd1);
    chk("lsb_b", b_l, 4'b1000);
    chk("lsb_dout_idle", {3'b0, dout_l}, 4'd0);
    next_cycle();
    chk("lsb_done_clear", {3'b0, done_l}, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
